oddr_gearbox_tx: RTL and testbench

Parallel-to-DDR serializer that sits directly upstream of the ODDRXC output register. It accepts WIDTH-bit words over a valid/ready handshake, buffers them in a small FIFO, and emits two bits per CLK cycle on DA/DB, LSB-pair first, for the DDR register to drive off-chip. When no data is available it drives a fixed idle level, so the pad never toggles on stale data.

---
 rtl/oddr_gearbox_tx.sv | 125 ++++++++++++
 tb/tb_oddr_gearbox_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oddr_gearbox_tx.sv
// Word-to-DDR-pair serializer feeding an ODDRXC: small FIFO in, two bits per CLK out, LSB pair first.
// Optional training-pattern injection is enabled by defining ODDR_GEARBOX_TRAIN_EN.
module oddr_gearbox_tx #(
    parameter int               WIDTH         = 8,
    parameter int               DEPTH         = 4,
    parameter logic             IDLE_DA       = 1'b0,
    parameter logic             IDLE_DB       = 1'b0,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hA5
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [WIDTH-1:0]         DIN,
    input  logic                     DIN_VALID,
`ifdef ODDR_GEARBOX_TRAIN_EN
    input  logic                     TRAIN,
`endif
    output logic                     DIN_READY,
    output logic                     DA,
    output logic                     DB,
    output logic                     TX_ACTIVE,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    localparam int               AW         = $clog2(DEPTH);
    localparam int               BW         = $clog2(WIDTH / 2);
    localparam logic [BW-1:0]    LAST_BEAT  = BW'(WIDTH / 2 - 1);
    localparam logic [AW:0]      FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               da_q, da_d, db_q, db_d, act_q, act_d;
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               train_w, push, pop, boundary, load_train, load;
    logic [WIDTH-1:0]   word_w;

`ifdef ODDR_GEARBOX_TRAIN_EN
    assign train_w = TRAIN;
`else
    assign train_w = 1'b0;
`endif

    assign DIN_READY  = (level_q != FULL_LEVEL) && RSTN;
    assign push       = DIN_VALID && DIN_READY;
    // A word boundary is any idle cycle or the edge that closes the last beat.
    assign boundary   = (state_q == S_IDLE) || (beat_q == LAST_BEAT);
    assign load_train = boundary && train_w;
    assign pop        = boundary && !train_w && (level_q != '0);
    assign load       = load_train || pop;
    assign word_w     = load_train ? TRAIN_PATTERN : mem_q[rd_ptr_q];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            shift_q  <= '0;
            da_q     <= IDLE_DA;
            db_q     <= IDLE_DB;
            act_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            shift_q  <= shift_d;
            da_q     <= da_d;
            db_q     <= db_d;
            act_q    <= act_d;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            level_q  <= level_q + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // Storage is data only; occupancy is tracked by the pointers and level.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DIN;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (load) begin
            state_d = S_SHIFT;
            beat_d  = '0;
        end else if (boundary) begin
            state_d = S_IDLE;
            beat_d  = '0;
        end else begin
            beat_d  = beat_q + 1'b1;
        end
    end

    always_comb begin
        shift_d = shift_q;
        da_d    = IDLE_DA;
        db_d    = IDLE_DB;
        act_d   = 1'b0;
        if (load) begin
            da_d    = word_w[0];
            db_d    = word_w[1];
            shift_d = word_w >> 2;
            act_d   = 1'b1;
        end else if (!boundary) begin
            da_d    = shift_q[0];
            db_d    = shift_q[1];
            shift_d = shift_q >> 2;
            act_d   = 1'b1;
        end
    end

    assign DA        = da_q;
    assign DB        = db_q;
    assign TX_ACTIVE = act_q;
    assign LEVEL     = level_q;

endmodule

// File: tb/tb_oddr_gearbox_tx.sv
// Scoreboard bench for oddr_gearbox_tx: stimulus queues expected (DA,DB) pairs, a negedge monitor checks them.
module tb_oddr_gearbox_tx;

    logic       CLK = 1'b0;
    logic       RSTN;
    logic [7:0] DIN;
    logic       DIN_VALID;
    logic       TRAIN;
    logic       DIN_READY, DA, DB, TX_ACTIVE;
    logic [2:0] LEVEL;

    oddr_gearbox_tx dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
`ifdef ODDR_GEARBOX_TRAIN_EN
        .TRAIN     (TRAIN),
`endif
        .DIN_READY (DIN_READY),
        .DA        (DA),
        .DB        (DB),
        .TX_ACTIVE (TX_ACTIVE),
        .LEVEL     (LEVEL)
    );

    always #5 CLK = ~CLK;

    logic [1:0] q [$];
    int n_pass   = 0;
    int n_total  = 0;
    int act_run  = 0;
    int last_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected pairs packed first-pair-first as {DA,DB} in the top two bits.
    function automatic logic [7:0] pairs_of(input logic [7:0] w);
        return {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
    endfunction

    task automatic push_exp(input logic [7:0] p);
        for (int k = 0; k < 4; k++) q.push_back(p[7-2*k -: 2]);
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] p, input bit do_push);
        int n;
        n = 0;
        DIN = w;
        DIN_VALID = 1'b1;
        @(negedge CLK);
        while (!DIN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!DIN_READY) begin
            n_total++;
            $display("FAIL ready_timeout: DIN_READY got 0, expected 1 within 200 cycles");
            DIN_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        if (do_push) push_exp(p);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((q.size() != 0 || TX_ACTIVE) && n < bound);
        @(posedge CLK);
        #1;
        chk("drain_done", int'(q.size() == 0 && !TX_ACTIVE), 1);
    endtask

    always @(negedge CLK) begin
        logic [1:0] e;
        if (RSTN) begin
            if (TX_ACTIVE) begin
                act_run++;
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_pair: got active pair %0d, expected idle (no word queued)", int'({DA, DB}));
                end else begin
                    e = q.pop_front();
                    chk("sb_pair", int'({DA, DB}), int'(e));
                end
            end else begin
                if (act_run > 0) last_run = act_run;
                act_run = 0;
                chk("idle_pair", int'({DA, DB}), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        RSTN = 1'b0;
        DIN_VALID = 1'b1;
        DIN = 8'hFF;
        TRAIN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", int'(DIN_READY), 0);
        chk("rst_level", int'(LEVEL), 0);
        chk("rst_active", int'(TX_ACTIVE), 0);
        chk("rst_da", int'(DA), 0);
        chk("rst_db", int'(DB), 0);
        @(posedge CLK);
        #1;
        DIN_VALID = 1'b0;
        RSTN = 1'b1;
        #1;
        chk("release_ready", int'(DIN_READY), 1);

        // single word B4 -> (0,0),(1,0),(1,1),(0,1)
        send(8'hB4, 8'b00_10_11_01, 1'b1);
        chk("single_level", int'(LEVEL), 1);
        DIN_VALID = 1'b0;
        wait_idle(50);
        chk("single_run", last_run, 4);

        // back-to-back stream: no idle gap across word boundaries
        send(8'h00, 8'b00_00_00_00, 1'b1);
        send(8'hFF, 8'b11_11_11_11, 1'b1);
        send(8'h5A, 8'b01_01_10_10, 1'b1);
        DIN_VALID = 1'b0;
        wait_idle(100);
        chk("stream_run", last_run, 12);

        // fill the FIFO while the first word shifts, then keep streaming past several pointer wraps
        for (int i = 0; i < 24; i++) begin
            w = 8'(i * 29 + 3);
            send(w, pairs_of(w), 1'b1);
            if (i == 4) begin
                chk("full_level", int'(LEVEL), 4);
                chk("full_ready", int'(DIN_READY), 0);
            end
        end
        DIN_VALID = 1'b0;
        wait_idle(400);

        // reset during beat 2 of C3
        send(8'hC3, 8'b11_00_00_11, 1'b1);
        DIN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        chk("midrst_da", int'(DA), 0);
        chk("midrst_db", int'(DB), 0);
        chk("midrst_active", int'(TX_ACTIVE), 0);
        chk("midrst_level", int'(LEVEL), 0);
        chk("midrst_ready", int'(DIN_READY), 0);
        q.delete();
        act_run = 0;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        send(8'h5A, 8'b01_01_10_10, 1'b1);
        DIN_VALID = 1'b0;
        wait_idle(50);
        chk("post_rst_run", last_run, 4);

`ifdef ODDR_GEARBOX_TRAIN_EN
        // three A5 pattern words, queued 3C/81 held back until TRAIN drops mid-word
        @(posedge CLK);
        #1;
        TRAIN = 1'b1;
        repeat (3) push_exp(8'b10_10_01_01);
        send(8'h3C, 8'b00_11_11_00, 1'b0);
        send(8'h81, 8'b10_00_00_01, 1'b0);
        DIN_VALID = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("train_level", int'(LEVEL), 2);
        TRAIN = 1'b0;
        push_exp(8'b00_11_11_00);
        push_exp(8'b10_00_00_01);
        wait_idle(100);
        chk("train_run", last_run, 20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
